// File: rtl/tile_mm_sched_if.sv
// Control bus between the tiled matrix-multiply sequencer and its RAM / vector MAC unit.
// The sequencer sits on the master side; the host, RAM and vector unit see the slave side.
interface tile_mm_sched_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int ROW_A      = 4
) ();
  // start is a single-cycle request with no ready: it is accepted only in IDLE and
  // silently dropped otherwise; every other signal is a registered strobe or address
  // that is valid in the cycle it is seen, with no back-pressure from RAM or MAC.
  logic                     start;
  logic                     load_a;
  logic                     load_w;
  logic [ADDR_WIDTH-1:0]    addr_a;
  logic [ADDR_WIDTH-1:0]    addr_w;
  logic                     deload_out;
  logic [ADDR_WIDTH-1:0]    addr_res;
  logic                     acc_clr;
  logic                     acc_en;
  logic [$clog2(ROW_A)-1:0] out_sel;
  logic                     busy;
  logic                     done;
  logic [2:0]               state_dbg;

  modport master (
    input  start,
    output load_a, load_w, addr_a, addr_w, deload_out, addr_res,
    output acc_clr, acc_en, out_sel, busy, done, state_dbg
  );

  modport slave (
    output start,
    input  load_a, load_w, addr_a, addr_w, deload_out, addr_res,
    input  acc_clr, acc_en, out_sel, busy, done, state_dbg
  );
endinterface

// File: rtl/tile_mm_sched.sv
// Tile sequencer for C = A x W: per output tile, N_DIM operand loads, a pipeline drain,
// then ROW_A row write-backs; accumulate strobes trail the loads by the RAM read latency.
module tile_mm_sched #(
  parameter int ADDR_WIDTH = 10,
  parameter int ROW_A      = 4,
  parameter int N_DIM      = 16,
  parameter int A_BASE     = 0,
  parameter int W_BASE     = 256,
  parameter int C_BASE     = 512,
  parameter int PIPE_LAT   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  tile_mm_sched_if.master   bus
);
  localparam int TILES     = N_DIM / ROW_A;
  localparam int TW        = (TILES > 1) ? $clog2(TILES) : 1;
  localparam int KW        = (N_DIM > 1) ? $clog2(N_DIM) : 1;
  localparam int JW        = $clog2(ROW_A);
  localparam int DRAIN_CYC = 2 + PIPE_LAT;
  localparam int DW        = $clog2(DRAIN_CYC + 1);
  localparam int AW        = ADDR_WIDTH;

  localparam logic [TW-1:0] T_LAST = TW'(TILES - 1);
  localparam logic [KW-1:0] K_LAST = KW'(N_DIM - 1);
  localparam logic [JW-1:0] J_LAST = JW'(ROW_A - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DRAIN = 3'd2,
    STORE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] r, r_n, c, c_n;
  logic [KW-1:0] k, k_n;
  logic [JW-1:0] j, j_n;
  logic [DW-1:0] d, d_n;
  logic [AW-1:0] addr_a_n, addr_w_n, addr_res_n;
  logic          first_q, load_d1, clr_d1;

  assign bus.state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      r     <= '0;
      c     <= '0;
      k     <= '0;
      j     <= '0;
      d     <= '0;
    end else begin
      state <= state_n;
      r     <= r_n;
      c     <= c_n;
      k     <= k_n;
      j     <= j_n;
      d     <= d_n;
    end
  end

  always_comb begin
    state_n = state;
    r_n     = r;
    c_n     = c;
    k_n     = k;
    j_n     = j;
    d_n     = d;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = LOAD;
          r_n     = '0;
          c_n     = '0;
          k_n     = '0;
        end
      end
      LOAD: begin
        if (k == K_LAST) begin
          state_n = DRAIN;
          d_n     = '0;
        end else begin
          k_n = k + KW'(1);
        end
      end
      DRAIN: begin
        if (d == D_LAST) begin
          state_n = STORE;
          j_n     = '0;
        end else begin
          d_n = d + DW'(1);
        end
      end
      STORE: begin
        if (j != J_LAST) begin
          j_n = j + JW'(1);
        end else if (r == T_LAST && c == T_LAST) begin
          state_n = DONE;
        end else begin
          // Column is the inner loop; the next tile's loads start with no idle gap.
          state_n = LOAD;
          k_n     = '0;
          if (c == T_LAST) begin
            c_n = '0;
            r_n = r + TW'(1);
          end else begin
            c_n = c + TW'(1);
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Addresses are formed from the next-cycle counters so the outputs can be registered
  // and still line up with the state being entered.
  always_comb begin
    addr_a_n   = AW'(A_BASE) + AW'(r_n) * AW'(ROW_A * N_DIM) + AW'(k_n);
    addr_w_n   = AW'(W_BASE) + AW'(k_n) * AW'(N_DIM) + AW'(c_n) * AW'(ROW_A);
    addr_res_n = AW'(C_BASE) + AW'(r_n) * AW'(ROW_A * N_DIM) + AW'(j_n) * AW'(N_DIM)
               + AW'(c_n) * AW'(ROW_A);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.load_a     <= 1'b0;
      bus.load_w     <= 1'b0;
      bus.addr_a     <= '0;
      bus.addr_w     <= '0;
      bus.deload_out <= 1'b0;
      bus.addr_res   <= '0;
      bus.out_sel    <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.acc_en     <= 1'b0;
      bus.acc_clr    <= 1'b0;
      first_q        <= 1'b0;
      load_d1        <= 1'b0;
      clr_d1         <= 1'b0;
    end else begin
      bus.load_a     <= (state_n == LOAD);
      bus.load_w     <= (state_n == LOAD);
      bus.deload_out <= (state_n == STORE);
      bus.busy       <= (state_n == LOAD) || (state_n == DRAIN) || (state_n == STORE);
      bus.done       <= (state_n == DONE);
      if (state_n == LOAD) begin
        bus.addr_a <= addr_a_n;
        bus.addr_w <= addr_w_n;
      end
      if (state_n == STORE) begin
        bus.addr_res <= addr_res_n;
        bus.out_sel  <= j_n;
      end
      // Two-stage delay matches the RAM read latency; it keeps shifting through DRAIN.
      first_q     <= (state_n == LOAD) && (k_n == '0);
      load_d1     <= bus.load_a;
      bus.acc_en  <= load_d1;
      clr_d1      <= first_q;
      bus.acc_clr <= clr_d1;
    end
  end
endmodule

// File: tb/tb_tile_mm_sched.sv
// Directed bench for tile_mm_sched: reset/idle, first-tile timing, tile order,
// completion timing and pulse totals, ignored start, and mid-run reset recovery.
module tb_tile_mm_sched;
  localparam int ADDR_WIDTH = 10;
  localparam int ROW_A      = 4;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   cyc;
  int   load_cnt;
  int   deload_cnt;
  int   done_cnt;

  tile_mm_sched_if #(.ADDR_WIDTH(ADDR_WIDTH), .ROW_A(ROW_A)) bus ();

  tile_mm_sched #(
    .ADDR_WIDTH(ADDR_WIDTH), .ROW_A(ROW_A), .N_DIM(16),
    .A_BASE(0), .W_BASE(256), .C_BASE(512), .PIPE_LAT(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (bus.load_a)     load_cnt++;
    if (bus.deload_out) deload_cnt++;
    if (bus.done)       done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.load_a, bus.load_w, bus.addr_a, bus.addr_w, bus.deload_out,
                bus.addr_res, bus.acc_clr, bus.acc_en, bus.out_sel, bus.busy, bus.done});
  endfunction

  // Pulses start for one cycle; on return cyc == 1 is the first cycle after acceptance.
  task automatic launch();
    load_cnt   = 0;
    deload_cnt = 0;
    done_cnt   = 0;
    cyc        = 0;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
  endtask

  task automatic first_tile_checks();
    check("t1_load_a", 64'(bus.load_a), 64'd1);
    check("t1_addr_a", 64'(bus.addr_a), 64'd0);
    check("t1_addr_w", 64'(bus.addr_w), 64'd256);
    check("t1_busy",   64'(bus.busy),   64'd1);
    goto(2);
    check("t2_addr_a", 64'(bus.addr_a), 64'd1);
    check("t2_addr_w", 64'(bus.addr_w), 64'd272);
    check("t2_acc_en", 64'(bus.acc_en), 64'd0);
    goto(3);
    check("t3_acc_en",  64'(bus.acc_en),  64'd1);
    check("t3_acc_clr", 64'(bus.acc_clr), 64'd1);
    goto(4);
    check("t4_acc_en",  64'(bus.acc_en),  64'd1);
    check("t4_acc_clr", 64'(bus.acc_clr), 64'd0);
    goto(21);
    check("t21_deload", 64'(bus.deload_out), 64'd0);
    for (int i = 0; i < 4; i++) begin
      goto(22 + i);
      check("store_deload",  64'(bus.deload_out), 64'd1);
      check("store_addr",    64'(bus.addr_res),   64'(512 + 16 * i));
      check("store_out_sel", 64'(bus.out_sel),    64'(i));
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    // Reset then idle.
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_outs", all_outs(), 64'd0);
    end

    // Full run with ignored start pulses inside it.
    launch();
    first_tile_checks();
    goto(5);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    goto(26);
    check("tile2_load_a",  64'(bus.load_a),     64'd1);
    check("tile2_addr_a",  64'(bus.addr_a),     64'd0);
    check("tile2_addr_w",  64'(bus.addr_w),     64'd260);
    check("tile2_deload",  64'(bus.deload_out), 64'd0);
    goto(28);
    check("tile2_acc_clr", 64'(bus.acc_clr),    64'd1);
    goto(47);
    check("tile2_addr_res", 64'(bus.addr_res),  64'd516);
    goto(101);
    check("tile_r1_addr_a", 64'(bus.addr_a),    64'd64);
    check("tile_r1_addr_w", 64'(bus.addr_w),    64'd256);
    goto(200);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    goto(400);
    check("last_deload",   64'(bus.deload_out), 64'd1);
    check("last_addr_res", 64'(bus.addr_res),   64'd764);
    check("last_busy",     64'(bus.busy),       64'd1);
    check("last_done",     64'(bus.done),       64'd0);
    goto(401);
    check("done_pulse",    64'(bus.done),       64'd1);
    check("done_busy",     64'(bus.busy),       64'd0);
    check("done_deload",   64'(bus.deload_out), 64'd0);
    goto(402);
    check("done_low",      64'(bus.done),       64'd0);
    goto(410);
    check("post_idle_busy", 64'(bus.busy),      64'd0);
    check("load_a_total",  64'(load_cnt),       64'd256);
    check("deload_total",  64'(deload_cnt),     64'd64);
    check("done_total",    64'(done_cnt),       64'd1);

    // Reset in the middle of a run.
    launch();
    goto(150);
    check("mid_busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst_outs", all_outs(), 64'd0);
    goto(160);
    check("rst_idle_outs", all_outs(), 64'd0);
    check("rst_no_done",   64'(done_cnt), 64'd0);

    // Restart after reset behaves like a fresh run.
    launch();
    first_tile_checks();
    goto(401);
    check("rerun_done", 64'(bus.done), 64'd1);
    goto(405);
    check("rerun_deload_total", 64'(deload_cnt), 64'd64);
    check("rerun_done_total",   64'(done_cnt),   64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tile_mm_sched.md
Name: tile_mm_sched

Overview:
- Sequencer for the tiled matrix-multiply datapath: shared operand/result RAM plus ROW_A-lane vector MAC unit.
- On a start pulse, walks every ROW_A x ROW_A output tile of an N_DIM x N_DIM product C = A x W.
- For each tile it issues K-step operand loads, waits out the MAC pipeline, then writes the tile back row by row.
- Drives the RAM's load_a/load_w/deload_out/address inputs and the vector unit's accumulate controls.

Parameters:
- ADDR_WIDTH, 10, RAM word address width.
- ROW_A, 4, lanes per bus beat; tile edge length.
- N_DIM, 16, matrix dimension (row stride); must be a multiple of ROW_A.
- A_BASE, 0, base address of A (row-major).
- W_BASE, 256, base address of W (row-major).
- C_BASE, 512, base address of C (row-major).
- PIPE_LAT, 3, cycles from last acc_en until the vector unit's out bus holds the final tile.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to run a full multiply.
- load_a  out  1  RAM: fetch A column slice at addr_a.
- load_w  out  1  RAM: fetch W row slice at addr_w.
- addr_a  out  ADDR_WIDTH  A slice address; RAM reads addr_a + i*N_DIM.
- addr_w  out  ADDR_WIDTH  W slice address; RAM reads addr_w + i.
- deload_out  out  1  RAM: write out bus at addr_res.
- addr_res  out  ADDR_WIDTH  result row address.
- acc_clr  out  1  vector unit: clear accumulators, then accumulate.
- acc_en  out  1  vector unit: accumulate current a/w.
- out_sel  out  $clog2(ROW_A)  vector unit: accumulator row driven onto out.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_n low at posedge): state IDLE; all outputs 0; all counters 0. Applies mid-sequence: no done pulse, nothing further issued. The vector unit and RAM pipeline residue is not flushed; the next run's acc_clr covers it.
- Counters:
  - r: tile row, 0..N_DIM/ROW_A-1, outer loop.
  - c: tile column, inner loop.
  - k: 0..N_DIM-1.
  - j: 0..ROW_A-1.
  - d: drain counter.
- States:
  - IDLE: start=1 -> LOAD with r=c=k=0. Otherwise stay.
  - LOAD: one cycle per k. load_a=load_w=1. addr_a = A_BASE + r*ROW_A*N_DIM + k. addr_w = W_BASE + k*N_DIM + c*ROW_A. When k=N_DIM-1 -> DRAIN, d=0.
  - DRAIN: all strobes 0 for exactly 2+PIPE_LAT cycles, then -> STORE with j=0.
  - STORE: one cycle per j. deload_out=1, out_sel=j, addr_res = C_BASE + (r*ROW_A+j)*N_DIM + c*ROW_A.
    - At j=ROW_A-1, if the tile was not last: advance c (wrap to 0 and increment r) -> LOAD with k=0 and no idle gap.
    - At j=ROW_A-1 on the last tile -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- busy: 1 in LOAD, DRAIN and STORE; 0 in IDLE and DONE.
- Accumulate alignment: RAM operands are valid 2 cycles after load_a/load_w.
  - acc_en is load_a delayed exactly 2 cycles.
  - acc_clr is 1 only on the acc_en cycle for k=0 of each tile.
  - The delay pipe keeps shifting in DRAIN, and is cleared by reset.
- Outputs: all registered. Addresses hold their last value when the matching strobe is 0.
- start while busy or in DONE: ignored, not queued.
- Address arithmetic: done at ADDR_WIDTH bits, wraps modulo 2^ADDR_WIDTH; no overflow flag.
- Cycles per tile = N_DIM + 2 + PIPE_LAT + ROW_A (25 at defaults). Full run = (N_DIM/ROW_A)^2 tiles (400 cycles at defaults). done arrives in the cycle after the last deload_out.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, release, keep start=0 for 20 cycles -> all outputs 0, busy=0 throughout.
- First tile: pulse start at cycle T.
  - -> T+1: load_a=1, addr_a=0, addr_w=256.
  - -> T+2: addr_a=1, addr_w=272.
  - -> T+3: acc_en=1, acc_clr=1.
  - -> T+4: acc_clr=0.
  - -> deload_out high T+22..T+25 with addr_res 512, 528, 544, 560 and out_sel 0..3.
- Tile order: second tile (r=0, c=1) -> first addr_w=260, addr_a=0, first addr_res=516. Tile r=1, c=0 -> first addr_a=64.
- Completion: full run from start at T.
  - -> last deload_out at T+400 with addr_res=764.
  - -> done=1 only at T+401; busy=0 from T+401.
  - -> exactly 64 deload_out and 256 load_a pulses.
- start while busy: extra start pulses at T+5 and T+200 -> trace identical to a single run, exactly one done pulse.
- Reset mid-run: rst_n=0 at T+150 for 1 cycle.
  - -> next cycle all outputs 0, no done.
  - -> new start -> trace again matches the first-tile scenario exactly.
